// File: rtl/data_memory.sv
// data_memory: byte-addressable little-endian data RAM with synchronous
// byte/half/word writes and combinational, optionally sign-extended reads.
module data_memory #(
    parameter int unsigned DEPTH_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [1:0]  byte_size,
    input  logic        sign_ext,
    output logic [31:0] read_data
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]    b0, b1, b2, b3;
    logic          unused_addr_hi;

    // Byte lanes of a multi-byte access wrap naturally at the top of memory
    assign idx0 = address[AW-1:0];
    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);

    // Upper address bits are deliberately ignored
    assign unused_addr_hi = ^address[31:AW];

    // Storage: cleared asynchronously in reset, byte-lane writes otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
                mem[AW'(i)] <= 8'h00;
            end
        end else if (memwrite) begin
            mem[idx0] <= write_data[7:0];
            if (byte_size != 2'b00) begin
                mem[idx1] <= write_data[15:8];
            end
            if (byte_size[1]) begin
                mem[idx2] <= write_data[23:16];
                mem[idx3] <= write_data[31:24];
            end
        end
    end

    assign b0 = mem[idx0];
    assign b1 = mem[idx1];
    assign b2 = mem[idx2];
    assign b3 = mem[idx3];

    // Load path: select field by size, then sign- or zero-extend
    always_comb begin
        read_data = 32'h0;
        if (rst_n && memread) begin
            case (byte_size)
                2'b00:   read_data = {{24{sign_ext & b0[7]}}, b0};
                2'b01:   read_data = {{16{sign_ext & b1[7]}}, b1, b0};
                default: read_data = {b3, b2, b1, b0};
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory; expected load values are
// queued as stimulus is driven and compared against captured read_data.
module tb_data_memory;

    localparam int unsigned DEPTH = 4096;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [1:0]  byte_size;
    logic        sign_ext;
    logic [31:0] read_data;

    logic [31:0] sb  [$];
    logic [31:0] obs [$];
    int n_cmp;
    int n_fail;

    data_memory #(.DEPTH_BYTES(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .byte_size  (byte_size),
        .sign_ext   (sign_ext),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write, committed at the next rising edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        address    = a;
        write_data = d;
        byte_size  = sz;
        memwrite   = 1'b1;
        memread    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        memwrite   = 1'b0;
    endtask

    // One combinational read; expected value goes to the scoreboard
    task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                      input logic [31:0] exp);
        @(negedge clk);
        address   = a;
        byte_size = sz;
        sign_ext  = sx;
        memwrite  = 1'b0;
        memread   = 1'b1;
        sb.push_back(exp);
        #1;
        obs.push_back(read_data);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        address  = 32'h40;
        byte_size = 2'b10;
        memread  = 1'b1;
        sb.push_back(32'h0);
        #1;
        obs.push_back(read_data);
        @(negedge clk);
        rst_n = 1'b1;
        rd(32'h40, 2'b10, 1'b0, 32'h0000_0000);
        drain("reset");
    endtask

    task automatic test_word();
        wr(32'h100, 32'hDEAD_BEEF, 2'b10);
        rd(32'h100, 2'b10, 1'b0, 32'hDEAD_BEEF);
        rd(32'h101, 2'b00, 1'b0, 32'h0000_00BE);
        rd(32'h101, 2'b00, 1'b1, 32'hFFFF_FFBE);
        rd(32'h100, 2'b11, 1'b1, 32'hDEAD_BEEF);
        rd(32'h100, 2'b01, 1'b1, 32'hFFFF_BEEF);
        rd(32'h103, 2'b00, 1'b0, 32'h0000_00DE);
        drain("word");
    endtask

    task automatic test_byte_write();
        wr(32'h102, 32'h0000_00A5, 2'b00);
        rd(32'h100, 2'b10, 1'b0, 32'hDEA5_BEEF);
        rd(32'h102, 2'b00, 1'b1, 32'hFFFF_FFA5);
        rd(32'h101, 2'b01, 1'b0, 32'h0000_A5BE);
        drain("byte_write");
    endtask

    task automatic test_half();
        wr(32'h200, 32'hFFFF_8001, 2'b01);
        rd(32'h200, 2'b01, 1'b0, 32'h0000_8001);
        rd(32'h200, 2'b01, 1'b1, 32'hFFFF_8001);
        rd(32'h200, 2'b10, 1'b0, 32'h0000_8001);
        wr(32'h202, 32'h0000_7FFF, 2'b01);
        rd(32'h200, 2'b10, 1'b0, 32'h7FFF_8001);
        rd(32'h202, 2'b01, 1'b1, 32'h0000_7FFF);
        rd(32'h201, 2'b01, 1'b1, 32'hFFFF_FF80);
        drain("half");
    endtask

    task automatic test_wrap();
        wr(DEPTH - 2, 32'h1122_3344, 2'b10);
        rd(DEPTH - 2, 2'b00, 1'b0, 32'h0000_0044);
        rd(DEPTH - 1, 2'b00, 1'b0, 32'h0000_0033);
        rd(32'h0,     2'b00, 1'b0, 32'h0000_0022);
        rd(32'h1,     2'b00, 1'b0, 32'h0000_0011);
        rd(DEPTH - 2, 2'b10, 1'b0, 32'h1122_3344);
        rd(DEPTH - 1, 2'b01, 1'b0, 32'h0000_2233);
        rd(32'h8000_0000 + DEPTH - 2, 2'b10, 1'b0, 32'h1122_3344);
        drain("wrap");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        address    = 32'h300;
        write_data = 32'h1234_5678;
        byte_size  = 2'b10;
        sign_ext   = 1'b0;
        memwrite   = 1'b1;
        memread    = 1'b1;
        sb.push_back(32'h0);
        #1;
        obs.push_back(read_data);
        @(posedge clk);
        #1;
        sb.push_back(32'h1234_5678);
        obs.push_back(read_data);
        @(negedge clk);
        memwrite = 1'b0;
        memread  = 1'b0;
        sb.push_back(32'h0);
        #1;
        obs.push_back(read_data);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        address    = 32'h300;
        write_data = 32'hCAFE_F00D;
        byte_size  = 2'b10;
        memwrite   = 1'b1;
        memread    = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(32'h0);
        obs.push_back(read_data);
        @(posedge clk);
        @(negedge clk);
        memwrite = 1'b0;
        rst_n    = 1'b1;
        rd(32'h300, 2'b10, 1'b0, 32'h0000_0000);
        rd(32'h100, 2'b10, 1'b0, 32'h0000_0000);
        rd(DEPTH - 2, 2'b10, 1'b0, 32'h0000_0000);
        drain("reset_mid");
    endtask

    // Compare every captured observation against its queued expectation
    task automatic drain(input string name);
        logic [31:0] e, o;
        int k;
        k = 0;
        if (sb.size() != obs.size()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s queue depth: got %0d observations, expected %0d", name, obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s[%0d]: read_data=%h expected=%h", name, k, o, e);
            end
            k++;
        end
        sb.delete();
        obs.delete();
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        memwrite   = 1'b0;
        memread    = 1'b0;
        byte_size  = 2'b00;
        sign_ext   = 1'b0;
        test_reset();
        test_word();
        test_byte_write();
        test_half();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
